// File: rtl/inv_key_sched_if.sv
// Handshake/bus bundle for the inverse AES-128 key scheduler.
// master: key loader / consumer side; slave: the scheduler itself.
interface inv_key_sched_if #(
    parameter int KEY_LEN = 128
);
    logic               start_valid;
    logic               start_ready;
    logic [KEY_LEN-1:0] last_key;
    logic [KEY_LEN-1:0] key_out;
    logic [3:0]         key_round;
    logic               key_valid;
    logic               key_ready;
    logic               busy;
    logic               done;

    modport master (
        output start_valid, last_key, key_ready,
        input  start_ready, key_out, key_round, key_valid, busy, done
    );

    modport slave (
        input  start_valid, last_key, key_ready,
        output start_ready, key_out, key_round, key_valid, busy, done
    );
endinterface

// File: rtl/inv_key_sched.sv
// Inverse AES-128 key scheduler: takes the round-NR key and emits round keys
// NR..0, deriving each earlier key by inverting the forward expansion.
module inv_key_sched #(
    parameter int KEY_LEN  = 128,
    parameter int WORD_LEN = 32,
    parameter int NR       = 10
) (
    input logic            clk,
    input logic            reset,
    inv_key_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EMIT, SUB, CALC} state_t;

    state_t                  state_q, state_d;
    logic [KEY_LEN-1:0]      key_q;
    logic [3:0]              round_q;
    logic [7:0]              rcon_q;
    logic [WORD_LEN-1:0]     sub_q;
    logic [3*WORD_LEN-1:0]   part_q;
    logic                    done_q;

    logic [WORD_LEN-1:0]     n0, n1, n2, n3;
    logic [WORD_LEN-1:0]     p0_c, p1_c, p2_c, p3_c;
    logic [WORD_LEN-1:0]     rot_c;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1B;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = x;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [WORD_LEN-1:0] sub_word(input logic [WORD_LEN-1:0] w);
        logic [WORD_LEN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WORD_LEN / 8; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
        return r;
    endfunction

    // Inverse of xtime: steps rcon backwards (36,1B,80,...,01)
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1B) >> 1) | 8'h80) : (x >> 1);
    endfunction

    assign n0 = key_q[3*WORD_LEN +: WORD_LEN];
    assign n1 = key_q[2*WORD_LEN +: WORD_LEN];
    assign n2 = key_q[WORD_LEN +: WORD_LEN];
    assign n3 = key_q[0 +: WORD_LEN];

    assign p3_c  = n3 ^ n2;
    assign p2_c  = n2 ^ n1;
    assign p1_c  = n1 ^ n0;
    assign rot_c = {p3_c[WORD_LEN-9:0], p3_c[WORD_LEN-1 -: 8]};
    // key_q still holds the newer key during CALC, so n0 is valid here
    assign p0_c  = n0 ^ sub_q ^ {rcon_q, {(WORD_LEN-8){1'b0}}};

    assign bus.key_out   = key_q;
    assign bus.key_round = round_q;
    assign bus.done      = done_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake/status outputs
    always_comb begin
        state_d         = state_q;
        bus.start_ready = 1'b0;
        bus.key_valid   = 1'b0;
        bus.busy        = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.start_ready = 1'b1;
                bus.busy        = 1'b0;
                if (bus.start_valid) state_d = EMIT;
            end
            EMIT: begin
                bus.key_valid = 1'b1;
                if (bus.key_ready) state_d = (round_q == '0) ? IDLE : SUB;
            end
            SUB:     state_d = CALC;
            CALC:    state_d = EMIT;
            default: state_d = IDLE;
        endcase
    end

    // Key datapath: load, partial XORs + registered S-box, final word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            sub_q   <= '0;
            part_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        key_q   <= bus.last_key;
                        round_q <= 4'(NR);
                        rcon_q  <= 8'h36;
                    end
                end
                EMIT: begin
                    if (bus.key_ready && round_q == '0) done_q <= 1'b1;
                end
                SUB: begin
                    part_q <= {p1_c, p2_c, p3_c};
                    sub_q  <= sub_word(rot_c);
                end
                CALC: begin
                    key_q   <= {p0_c, part_q};
                    round_q <= round_q - 4'd1;
                    rcon_q  <= inv_xtime(rcon_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inv_key_sched.md
# inv_key_sched

Inverse AES-128 key scheduler for the decryption datapath. It accepts the final (round-10) round key and emits the round keys in reverse order, round 10 down to round 0, one 128-bit key per valid/ready handshake. Each earlier round key is derived on the fly by inverting the forward expansion, so no 11-entry key RAM is needed. It sits between the key-load path and the inverse-cipher AddRoundKey stage.

## Interface
- KEY_LEN, 128, round key width (only 128 supported)
- WORD_LEN, 32, word width (SubWord instance width)
- NR, 10, number of rounds; first emitted round index

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- start_valid  in  1  last_key is valid; request a new reverse schedule
- start_ready  out  1  block idle, can accept start
- last_key  in  KEY_LEN  round-NR key; word0 = [127:96] … word3 = [31:0]
- key_out  out  KEY_LEN  current round key
- key_round  out  4  round index of key_out (NR..0)
- key_valid  out  1  key_out/key_round valid
- key_ready  in  1  consumer accepts key_out
- busy  out  1  schedule in progress (not IDLE)
- done  out  1  one-cycle pulse after round-0 key handshake

## Operation
- Reset: key_out=0, key_round=0, key_valid=0, done=0, busy=0, start_ready=1, rcon register=0, state=IDLE.
- FSM states: IDLE, EMIT, SUB, CALC.
  - IDLE: start_ready=1. On start_valid: key_out<=last_key, key_round<=NR, rcon<=8'h36, -> EMIT. start_valid is ignored in all other states.
  - EMIT: key_valid=1; key_out/key_round held stable until key_ready. On handshake: if key_round==0 -> pulse done, -> IDLE; else -> SUB.
  - SUB: register partial words of the previous key, p3=n3^n2, p2=n2^n1, p1=n1^n0 (n = current key_out words). Drive the S-box with RotWord(p3) = {p3[23:0], p3[31:24]}. -> CALC.
  - CALC: S-box result S is available (registered S-box, 1-cycle latency). p0 = n0 ^ S ^ {rcon, 24'h0}. key_out<={p0,p1,p2,p3}, key_round<=key_round-1, rcon<=inv_xtime(rcon). -> EMIT.
- inv_xtime(x): if x[0]=0 then x>>1, else ((x^8'h1B)>>1)|8'h80. This gives the sequence 36,1B,80,40,20,10,08,04,02,01.
- busy=1 in EMIT/SUB/CALC. start_ready = (state==IDLE).
- key_valid is low in SUB and CALC. key_out changes only on the CALC->EMIT edge or on start acceptance.
- Asynchronous reset mid-schedule aborts immediately to the reset values; no partial key is emitted afterwards.

## Timing
- Start accepted at edge T: key_valid=1 with round 10 in the cycle after T.
- Key handshake at edge H (round>0): SUB cycle H+1, CALC cycle H+2, next key_valid in cycle H+3. Minimum spacing is 3 cycles per key.
- Full schedule with key_ready held high: 11 keys in 31 cycles from first key_valid to last handshake. done is high in the cycle after the round-0 handshake, and start_ready returns in that same cycle.
- Back-to-back: a start presented in the done cycle is accepted at that edge.
- key_ready low stalls EMIT indefinitely, with no change to outputs or rcon.
- A key_ready pulse while key_valid=0 has no effect.

## Test plan
- FIPS-197 vector: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1. Required outputs:
  - round 10 = last_key;
  - round 9 = ac7766f319fadc2128d12941575c006e;
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c;
  - done pulses once; 31-cycle schedule.
- Backpressure: randomly deassert key_ready. The key sequence must be identical to the vector test, key_out must be stable while key_valid&&!key_ready, and each key must be handshaked exactly once.
- Ignored start: assert start_valid with a different key mid-schedule. The current sequence must be unaffected, and start_ready=0 throughout.
- Reset mid-operation: drop reset during round 5 SUB. The next cycle must show all outputs at reset values. A new start afterwards must reproduce the full vector.
- Back-to-back: issue a second start in the done cycle with the FIPS round-10 key. The second sequence must begin with round 10 in the next cycle and match the vector.
- Rcon check: across all 10 derivations, the internal rcon must follow 36,1B,80,40,20,10,08,04,02,01. Cross-check all 11 keys against a forward-expansion software model for 100 random keys.
